// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers issued ALU/branch/jump ops, snoops ALU/LSB buses, feeds EX.
// Latency: ready-at-issue op dispatches the next cycle; its result is on alu_* the cycle after.
// Backpressure: full is raised when no entry is free; issues arriving while full are dropped.
module alu_reservation_station #(
    parameter int RS_SIZE   = 8,
    parameter int RS_WIDTH  = 3,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 issue_valid,
    input  logic [5:0]           issue_order,
    input  logic [31:0]          issue_vj,
    input  logic [31:0]          issue_vk,
    input  logic                 issue_qj_valid,
    input  logic                 issue_qk_valid,
    input  logic [ROB_WIDTH-1:0] issue_qj,
    input  logic [ROB_WIDTH-1:0] issue_qk,
    input  logic [31:0]          issue_A,
    input  logic [31:0]          issue_pc,
    input  logic [ROB_WIDTH-1:0] issue_rob_id,
    input  logic                 lsb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,
    output logic [5:0]           ex_order,
    output logic [31:0]          ex_vj,
    output logic [31:0]          ex_vk,
    output logic [31:0]          ex_A,
    output logic [31:0]          ex_pc,
    input  logic [31:0]          ex_value,
    input  logic [31:0]          ex_topc,
    output logic                 full,
    output logic                 alu_valid,
    output logic [ROB_WIDTH-1:0] alu_rob_id,
    output logic [31:0]          alu_value,
    output logic [31:0]          alu_topc
);

    typedef struct packed {
        logic                 busy;
        logic [5:0]           order;
        logic [31:0]          vj;
        logic [31:0]          vk;
        logic                 qj_valid;
        logic [ROB_WIDTH-1:0] qj;
        logic                 qk_valid;
        logic [ROB_WIDTH-1:0] qk;
        logic [31:0]          a;
        logic [31:0]          pc;
        logic [ROB_WIDTH-1:0] rob_id;
    } entry_t;

    entry_t               ent_q [RS_SIZE];
    entry_t               ent_d [RS_SIZE];
    entry_t               new_ent;

    logic                 alu_valid_q,  alu_valid_d;
    logic [ROB_WIDTH-1:0] alu_rob_id_q, alu_rob_id_d;
    logic [31:0]          alu_value_q,  alu_value_d;
    logic [31:0]          alu_topc_q,   alu_topc_d;

    logic [RS_WIDTH-1:0]  free_idx;
    logic [RS_WIDTH-1:0]  disp_idx;
    logic                 disp_vld;

    // Priority pick: lowest free slot for issue, lowest ready slot for dispatch, plus full flag.
    always_comb begin
        free_idx = '0;
        disp_idx = '0;
        disp_vld = 1'b0;
        full     = 1'b1;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                free_idx = RS_WIDTH'(i);
                full     = 1'b0;
            end
            if (ent_q[i].busy && !ent_q[i].qj_valid && !ent_q[i].qk_valid) begin
                disp_idx = RS_WIDTH'(i);
                disp_vld = 1'b1;
            end
        end
    end

    // Drive EX from the selected entry; zeros when nothing is ready.
    always_comb begin
        ex_order = '0;
        ex_vj    = '0;
        ex_vk    = '0;
        ex_A     = '0;
        ex_pc    = '0;
        if (disp_vld) begin
            ex_order = ent_q[disp_idx].order;
            ex_vj    = ent_q[disp_idx].vj;
            ex_vk    = ent_q[disp_idx].vk;
            ex_A     = ent_q[disp_idx].a;
            ex_pc    = ent_q[disp_idx].pc;
        end
    end

    // Build the incoming entry, forwarding an operand that is on a bus in the issue cycle.
    always_comb begin
        new_ent          = '0;
        new_ent.busy     = 1'b1;
        new_ent.order    = issue_order;
        new_ent.vj       = issue_vj;
        new_ent.vk       = issue_vk;
        new_ent.qj_valid = issue_qj_valid;
        new_ent.qj       = issue_qj;
        new_ent.qk_valid = issue_qk_valid;
        new_ent.qk       = issue_qk;
        new_ent.a        = issue_A;
        new_ent.pc       = issue_pc;
        new_ent.rob_id   = issue_rob_id;
        if (issue_qj_valid) begin
            if (alu_valid_q && alu_rob_id_q == issue_qj) begin
                new_ent.vj       = alu_value_q;
                new_ent.qj_valid = 1'b0;
            end else if (lsb_valid && lsb_rob_id == issue_qj) begin
                new_ent.vj       = lsb_value;
                new_ent.qj_valid = 1'b0;
            end
        end
        if (issue_qk_valid) begin
            if (alu_valid_q && alu_rob_id_q == issue_qk) begin
                new_ent.vk       = alu_value_q;
                new_ent.qk_valid = 1'b0;
            end else if (lsb_valid && lsb_rob_id == issue_qk) begin
                new_ent.vk       = lsb_value;
                new_ent.qk_valid = 1'b0;
            end
        end
    end

    // Next state: capture, dispatch, issue, then stall/flush overrides on top.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && ent_q[i].qj_valid) begin
                if (alu_valid_q && alu_rob_id_q == ent_q[i].qj) begin
                    ent_d[i].vj       = alu_value_q;
                    ent_d[i].qj_valid = 1'b0;
                end else if (lsb_valid && lsb_rob_id == ent_q[i].qj) begin
                    ent_d[i].vj       = lsb_value;
                    ent_d[i].qj_valid = 1'b0;
                end
            end
            if (ent_q[i].busy && ent_q[i].qk_valid) begin
                if (alu_valid_q && alu_rob_id_q == ent_q[i].qk) begin
                    ent_d[i].vk       = alu_value_q;
                    ent_d[i].qk_valid = 1'b0;
                end else if (lsb_valid && lsb_rob_id == ent_q[i].qk) begin
                    ent_d[i].vk       = lsb_value;
                    ent_d[i].qk_valid = 1'b0;
                end
            end
        end

        alu_valid_d  = disp_vld;
        alu_rob_id_d = alu_rob_id_q;
        alu_value_d  = alu_value_q;
        alu_topc_d   = alu_topc_q;
        if (disp_vld) begin
            ent_d[disp_idx].busy = 1'b0;
            alu_rob_id_d         = ent_q[disp_idx].rob_id;
            alu_value_d          = ex_value;
            alu_topc_d           = ex_topc;
        end

        // The free slot is never the dispatching one, so both writes can coexist.
        if (issue_valid && !full) begin
            ent_d[free_idx] = new_ent;
        end

        if (!rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i] = ent_q[i];
            end
            alu_valid_d  = 1'b0;
            alu_rob_id_d = alu_rob_id_q;
            alu_value_d  = alu_value_q;
            alu_topc_d   = alu_topc_q;
        end else if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i]      = ent_q[i];
                ent_d[i].busy = 1'b0;
            end
            alu_valid_d  = 1'b0;
            alu_rob_id_d = alu_rob_id_q;
            alu_value_d  = alu_value_q;
            alu_topc_d   = alu_topc_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            alu_valid_q  <= 1'b0;
            alu_rob_id_q <= '0;
            alu_value_q  <= '0;
            alu_topc_q   <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
            alu_valid_q  <= alu_valid_d;
            alu_rob_id_q <= alu_rob_id_d;
            alu_value_q  <= alu_value_d;
            alu_topc_q   <= alu_topc_d;
        end
    end

    assign alu_valid  = alu_valid_q;
    assign alu_rob_id = alu_rob_id_q;
    assign alu_value  = alu_value_q;
    assign alu_topc   = alu_topc_q;

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Tomasulo reservation station that feeds the combinational EX ALU.
- Buffers issued ALU/branch/jump instructions and captures pending operands from the ALU and LSB broadcast buses.
- Selects one ready entry per cycle and drives EX's order/vj/vk/A/pc inputs.
- Registers EX's value/topc onto the ALU broadcast bus, tagged with the entry's ROB id.

Parameters:
RS_SIZE, 8, number of entries (power of two)
RS_WIDTH, 3, log2(RS_SIZE)
ROB_WIDTH, 4, ROB tag width

Ports:
clk_in  input  1  clock, all state changes on rising edge
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; 0 freezes all state
clear  input  1  mispredict flush, synchronous
issue_valid  input  1  decoder issues one instruction this cycle
issue_order  input  6  EX opcode encoding (LUI=0 … BGEU=36)
issue_vj / issue_vk  input  32  operand values, valid when matching q_valid=0
issue_qj_valid / issue_qk_valid  input  1  operand still pending
issue_qj / issue_qk  input  ROB_WIDTH  producer ROB tag
issue_A  input  32  immediate
issue_pc  input  32  instruction PC
issue_rob_id  input  ROB_WIDTH  destination ROB tag
lsb_valid  input  1  LSB broadcast valid
lsb_rob_id  input  ROB_WIDTH  LSB broadcast tag
lsb_value  input  32  LSB broadcast value
ex_order  output  6  to EX
ex_vj / ex_vk / ex_A / ex_pc  output  32  to EX
ex_value / ex_topc  input  32  from EX, combinational
full  output  1  no free entry (combinational from registered state)
alu_valid  output  1  registered ALU broadcast valid
alu_rob_id  output  ROB_WIDTH  registered tag
alu_value  output  32  registered EX value
alu_topc  output  32  registered EX topc

Behaviour:
- Reset (rst_in=1 at edge):
  - All entries invalid.
  - alu_valid=0; alu_rob_id=0; alu_value=0; alu_topc=0.
  - full=0 from the following cycle.
- Priority at an edge: rst_in > rdy_in=0 > clear > normal.
- rdy_in=0: entries hold; alu_* registers hold except alu_valid, which is forced to 0.
- clear: all entries invalidated; alu_valid=0 next cycle; issue and dispatch ignored that cycle.
- Entry fields: busy, order, vj, vk, qj_valid, qj, qk_valid, qk, A, pc, rob_id.
- An entry is ready when busy & !qj_valid & !qk_valid.
- Issue:
  - When issue_valid & !full, write the lowest-index non-busy entry.
  - Issue while full is dropped; the bench flags this as an error, and the decoder must gate on full.
  - Issue-time forwarding: if issue_qX_valid and an active bus (lsb, or registered alu_valid) carries tag issue_qX, store that bus value with qX_valid=0.
- Capture: each busy entry with qX_valid compares qX against alu_rob_id (if alu_valid) and lsb_rob_id (if lsb_valid); on a match, load the value and clear qX_valid. Both buses may match different operands of one entry in the same cycle.
- Dispatch:
  - Combinationally select the lowest-index ready entry and drive its order/vj/vk/A/pc onto ex_*.
  - With no ready entry, ex_* = 0.
  - At the edge, alu_valid=1, alu_rob_id=entry.rob_id, alu_value=ex_value, alu_topc=ex_topc, and the entry becomes free.
  - Otherwise alu_valid=0.
- Latency:
  - An entry issued ready at edge t dispatches in cycle t+1; its result is visible on alu_* in cycle t+2.
  - An operand captured at edge t allows dispatch in cycle t+1.
- A slot freed by dispatch at edge t is reusable from cycle t+1; full is not bypassed.
- Single dispatch and single issue per cycle. Issue into a slot and dispatch from another slot in the same cycle are both legal.
- Entries with no register operands (LUI, AUIPC, JAL) issue with both q_valid=0.

Test Plan:
- Reset: hold rst_in=1 for 2 cycles with issue_valid=1 -> alu_valid=0, full=0, alu_* = 0, and no entry written.
- Ready ADD: issue order=2, vj=5, vk=7, rob=3 -> ex_order=2 in the next cycle; the cycle after, alu_valid=1, alu_rob_id=3, alu_value=12.
- Pending operand: issue SUB, qj=5 pending, vk=1, rob=2; two cycles later lsb_valid with tag 5, value 10 -> alu_value=9, rob 2, valid exactly 2 cycles after the lsb pulse.
- Forward at issue and JALR: issue JALR (order 12), qj=6, A=8, pc=0x100 in the same cycle lsb broadcasts tag 6, value 0x201 -> alu_value=0x104, alu_topc=0x208.
- Full/priority:
  - Issue 8 entries all waiting on tag 9 -> full=1; a 9th issue leaves state unchanged.
  - Broadcast tag 9 -> dispatches proceed lowest index first, one per cycle, 8 consecutive alu_valid pulses.
  - full=0 the cycle after the first dispatch.
- Flush: with 4 busy entries, assert clear together with issue_valid -> next cycle full=0, alu_valid=0; no results appear afterwards.
